// File: rtl/sb_rdi_cfg_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sb_rdi_cfg_tx_arbiter
// Description : Sideband RDI pl_cfg transmit arbiter and sequencer. Shares the
//               single 32-bit pl_cfg lane between NUM_REQ packet sources,
//               gates each packet start on adapter credit availability and
//               streams the granted 64/128-bit packet as 2/4 beats under one
//               continuous valid pulse, followed by a one-cycle valid gap.
// Config      : SB_ARB_FIXED_PRIO_EN - defined: fixed priority (lowest index
//               wins, no pointer); undefined: round-robin arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_rdi_cfg_tx_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int CFG_W   = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [NUM_REQ-1:0]     i_req_has_data,
    input  logic [NUM_REQ*128-1:0] i_req_pkt,
    input  logic                   i_adapter_is_full,
    output logic [NUM_REQ-1:0]     o_gnt,
    output logic [CFG_W-1:0]       o_pl_cfg,
    output logic                   o_pl_cfg_vld,
    output logic                   o_busy
);

    localparam int c_idx_w = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [127:0]         r_pkt;
    logic [1:0]           r_beat;
    logic [1:0]           r_beat_last;
    logic [1:0]           w_beat_nxt;
    logic                 w_load;
    logic                 w_found;
    logic [c_idx_w-1:0]   w_win;
    logic [NUM_REQ-1:0]   w_gnt_nxt;
    logic [CFG_W-1:0]     w_cfg_nxt;
    logic                 w_vld_nxt;

`ifdef SB_ARB_FIXED_PRIO_EN
    // Fixed priority: scan high to low so the lowest requesting index wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_found = 1'b1;
                w_win   = c_idx_w'(i);
            end
        end
    end
`else
    localparam int                 c_sum_w   = c_idx_w + 1;
    localparam logic [c_sum_w-1:0] c_num_req = c_sum_w'(NUM_REQ);

    logic [c_idx_w-1:0] r_last;
    logic [c_sum_w-1:0] w_cand;

    // Round-robin: candidates last+1 .. last+NUM_REQ (mod NUM_REQ); scanning
    // from the far end lets the nearest requesting candidate win.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_cand = {1'b0, r_last} + c_sum_w'(i);
            if (w_cand >= c_num_req) begin
                w_cand = w_cand - c_num_req;
            end
            if (i_req[w_cand[c_idx_w-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[c_idx_w-1:0];
            end
        end
    end

    // Last-grant pointer; reset value makes requester 0 first in line.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= c_idx_w'(NUM_REQ - 1);
        end else if (w_load) begin
            r_last <= w_win;
        end
    end
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode; outputs are registered below so no
    // input reaches an output combinationally.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_load      = 1'b0;
        w_gnt_nxt   = '0;
        w_cfg_nxt   = '0;
        w_vld_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found && !i_adapter_is_full) begin
                    w_state_nxt = ST_SEND;
                    w_load      = 1'b1;
                    w_beat_nxt  = 2'd0;
                    w_gnt_nxt   = NUM_REQ'(1) << w_win;
                    w_cfg_nxt   = i_req_pkt[{w_win, 7'd0} +: CFG_W];
                    w_vld_nxt   = 1'b1;
                end
            end
            ST_SEND: begin
                if (r_beat == r_beat_last) begin
                    w_state_nxt = ST_GAP;
                end else begin
                    w_beat_nxt = r_beat + 2'd1;
                    w_cfg_nxt  = r_pkt[{w_beat_nxt, 5'd0} +: CFG_W];
                    w_vld_nxt  = 1'b1;
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Packet latch, beat tracking and registered outputs; reset drops any
    // partially sent packet.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pkt        <= '0;
            r_beat       <= '0;
            r_beat_last  <= '0;
            o_gnt        <= '0;
            o_pl_cfg     <= '0;
            o_pl_cfg_vld <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            if (w_load) begin
                r_pkt       <= i_req_pkt[{w_win, 7'd0} +: 128];
                r_beat_last <= i_req_has_data[w_win] ? 2'd3 : 2'd1;
            end
            r_beat       <= w_beat_nxt;
            o_gnt        <= w_gnt_nxt;
            o_pl_cfg     <= w_cfg_nxt;
            o_pl_cfg_vld <= w_vld_nxt;
            o_busy       <= (w_state_nxt != ST_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sb_rdi_cfg_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sb_rdi_cfg_tx_arbiter
// Description : Self-checking bench for sb_rdi_cfg_tx_arbiter: vector table,
//               hand-written corner sequences and a randomized run against a
//               packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sb_rdi_cfg_tx_arbiter;

    localparam int NR = 3;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR-1:0]     hd;
    logic [127:0]      pkt [NR];
    logic [NR*128-1:0] pkt_flat;
    logic              full;
    logic [NR-1:0]     o_gnt;
    logic [31:0]       o_pl_cfg;
    logic              o_pl_cfg_vld;
    logic              o_busy;

    int checks = 0;
    int errors = 0;

    sb_rdi_cfg_tx_arbiter #(.NUM_REQ(NR), .CFG_W(32)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_req             (req),
        .i_req_has_data    (hd),
        .i_req_pkt         (pkt_flat),
        .i_adapter_is_full (full),
        .o_gnt             (o_gnt),
        .o_pl_cfg          (o_pl_cfg),
        .o_pl_cfg_vld      (o_pl_cfg_vld),
        .o_busy            (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flatten per-requester packets onto the DUT bus.
    always_comb begin
        pkt_flat = '0;
        for (int r = 0; r < NR; r++) pkt_flat[r*128 +: 128] = pkt[r];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [NR-1:0] onehot(input int w);
        logic [NR-1:0] v;
        v = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    // Called at the sample just after the grant edge; checks all beats and
    // the gap cycle. full_at >= 0 raises full during that beat.
    task automatic expect_pkt(input int w, input int nb, input int full_at);
        chk("gnt", o_gnt, onehot(w));
        for (int k = 0; k < nb; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                chk("gnt_pulse", o_gnt, '0);
            end
            chk("beat", {o_pl_cfg_vld, o_pl_cfg}, {1'b1, pkt[w][32*k +: 32]});
            chk("busy_send", o_busy, 1'b1);
            if (k == full_at) begin
                @(negedge clk);
                full = 1'b1;
            end
        end
        @(posedge clk); #1;
        chk("gap", {o_busy, o_pl_cfg_vld, o_pl_cfg, o_gnt}, {1'b1, 1'b0, 32'd0, {NR{1'b0}}});
    endtask

    // Reference model: packet-level cycle list per grant.
    typedef struct packed {
        logic [NR-1:0] gnt;
        logic [31:0]   cfg;
        logic          vld;
        logic          busy;
    } exp_t;

    exp_t q[$];
    int   mptr;

    function automatic int pick(input logic [NR-1:0] rq);
`ifdef SB_ARB_FIXED_PRIO_EN
        for (int r = 0; r < NR; r++) if (rq[r]) return r;
`else
        for (int i = 1; i <= NR; i++) if (rq[(mptr + i) % NR]) return (mptr + i) % NR;
`endif
        return -1;
    endfunction

    typedef struct {
        logic [NR-1:0] req;
        logic [NR-1:0] hd;
        logic          full;
        logic [NR-1:0] gnt_rr;
        logic [NR-1:0] gnt_fx;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [NR-1:0] exp_g;
        logic [NR:0]   acc;
        logic [NR-1:0] gseen;
        logic          prev_vld;
        int            w;
        int            rises;
        int            npk;
        exp_t          e;

        tbl[0] = '{3'b001, 3'b000, 1'b0, 3'b001, 3'b001};
        tbl[1] = '{3'b100, 3'b100, 1'b0, 3'b100, 3'b100};
        tbl[2] = '{3'b111, 3'b000, 1'b1, 3'b000, 3'b000};
        tbl[3] = '{3'b111, 3'b000, 1'b0, 3'b001, 3'b001};
        tbl[4] = '{3'b111, 3'b010, 1'b0, 3'b010, 3'b001};
        tbl[5] = '{3'b111, 3'b100, 1'b0, 3'b100, 3'b001};
        tbl[6] = '{3'b111, 3'b001, 1'b0, 3'b001, 3'b001};
        tbl[7] = '{3'b101, 3'b001, 1'b0, 3'b100, 3'b001};
        tbl[8] = '{3'b011, 3'b010, 1'b0, 3'b001, 3'b001};
        tbl[9] = '{3'b110, 3'b000, 1'b0, 3'b010, 3'b010};

        pkt[0] = {64'h0123_4567_89AB_CDEF, 64'hAAAA_BBBB_CCCC_DDDD};
        pkt[1] = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
        pkt[2] = {64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000};
        req = '0; hd = '0; full = 1'b0; rst_n = 1'b0;

        // Reset state
        @(posedge clk); #1;
        chk("reset", {o_gnt, o_pl_cfg, o_pl_cfg_vld, o_busy}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req = tbl[i].req; hd = tbl[i].hd; full = tbl[i].full;
`ifdef SB_ARB_FIXED_PRIO_EN
            exp_g = tbl[i].gnt_fx;
`else
            exp_g = tbl[i].gnt_rr;
`endif
            if (exp_g == '0) begin
                acc = '0;
                for (int c = 0; c < 10; c++) begin
                    @(posedge clk); #1;
                    acc = acc | {o_gnt, o_pl_cfg_vld};
                end
                chk("no_grant_full", acc, '0);
            end else begin
                w = 0;
                for (int r = 0; r < NR; r++) if (exp_g[r]) w = r;
                @(posedge clk); #1;
                expect_pkt(w, tbl[i].hd[w] ? 4 : 2, -1);
                @(negedge clk);
                req = '0; full = 1'b0;
                @(posedge clk); #1;
                chk("idle", {o_busy, o_pl_cfg_vld, o_gnt}, '0);
            end
        end

        // Full rises during beat 1 of a 4-beat packet
        @(negedge clk);
        req = 3'b100; hd = 3'b100; full = 1'b0;
        @(posedge clk); #1;
        expect_pkt(2, 4, 1);
        @(negedge clk);
        req = 3'b111;
        acc = '0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            acc = acc | {o_gnt, o_pl_cfg_vld};
        end
        chk("no_grant_while_full", acc, '0);
        @(negedge clk);
        full = 1'b0;
        @(posedge clk); #1;
        expect_pkt(0, 2, -1);
        @(negedge clk);
        req = '0;

        // Async reset during beat 2
        @(negedge clk);
        req = 3'b001; hd = 3'b001;
        @(posedge clk); #1;
        chk("rst_seq_gnt", o_gnt, 3'b001);
        for (int k = 1; k < 3; k++) begin
            @(posedge clk); #1;
        end
        chk("beat2_before_rst", {o_pl_cfg_vld, o_pl_cfg}, {1'b1, pkt[0][95:64]});
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {o_gnt, o_pl_cfg, o_pl_cfg_vld, o_busy}, '0);
        req = 3'b111; hd = 3'b000;
        @(posedge clk); #1;
        chk("rst_held", {o_gnt, o_pl_cfg, o_pl_cfg_vld, o_busy}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_pkt(0, 2, -1);
        @(negedge clk);
        req = '0;

        // Randomized run against the reference model
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mptr = NR - 1;
        gseen = '0;
        prev_vld = 1'b0;
        rises = 0;
        npk = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            for (int r = 0; r < NR; r++) begin
                if (req[r] && gseen[r]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        req[r] = 1'b0;
                    end else begin
                        pkt[r] = {$urandom(), $urandom(), $urandom(), $urandom()};
                        hd[r]  = ($urandom_range(1, 0) == 1);
                    end
                end else if (!req[r] && $urandom_range(2, 0) == 0) begin
                    req[r] = 1'b1;
                    pkt[r] = {$urandom(), $urandom(), $urandom(), $urandom()};
                    hd[r]  = ($urandom_range(1, 0) == 1);
                end
            end
            full = ($urandom_range(4, 0) == 0);
            @(posedge clk);
            if (q.size() == 0 && req != '0 && !full) begin
                w = pick(req);
                for (int k = 0; k < (hd[w] ? 4 : 2); k++)
                    q.push_back('{(k == 0) ? onehot(w) : '0, pkt[w][32*k +: 32], 1'b1, 1'b1});
                q.push_back('{'0, 32'd0, 1'b0, 1'b1});
                q.push_back('{'0, 32'd0, 1'b0, 1'b0});
                mptr = w;
                npk++;
            end
            #1;
            e = (q.size() != 0) ? q.pop_front() : exp_t'('0);
            chk("rand", {o_gnt, o_pl_cfg, o_pl_cfg_vld, o_busy}, e);
            if (o_pl_cfg_vld && !prev_vld) rises++;
            prev_vld = o_pl_cfg_vld;
            gseen = o_gnt;
        end
        chk("vld_rises_per_pkt", 64'(rises), 64'(npk));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
